// File: rtl/threefish_iter_core.sv
// Iterative Threefish-256/512 encryption engine: UNROLL rounds per clock,
// key schedule generated on the fly from registered key/tweak words.
module threefish_iter_core #(
    parameter int NW     = 8,
    parameter int UNROLL = 1
) (
    input  logic             inClk,
    input  logic             inRstN,
    input  logic             inValid,
    output logic             outReady,
    input  logic [64*NW-1:0] inKey,
    input  logic [127:0]     inTweak,
    input  logic [64*NW-1:0] inBlock,
    output logic             outValid,
    input  logic             inReady,
    output logic [64*NW-1:0] outBlock
);

    if (!((NW == 4) || (NW == 8))) begin : g_bad_nw
        $error("threefish_iter_core: NW must be 4 or 8");
    end
    if (!((UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4))) begin : g_bad_unroll
        $error("threefish_iter_core: UNROLL must be 1, 2 or 4");
    end

    localparam int          NR   = 72;
    localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;

    localparam logic [5:0] ROT4 [8][2] = '{
        '{6'd14, 6'd16}, '{6'd52, 6'd57}, '{6'd23, 6'd40}, '{6'd5,  6'd37},
        '{6'd25, 6'd33}, '{6'd46, 6'd12}, '{6'd58, 6'd22}, '{6'd32, 6'd32}};
    localparam logic [5:0] ROT8 [8][4] = '{
        '{6'd46, 6'd36, 6'd19, 6'd37}, '{6'd33, 6'd27, 6'd14, 6'd42},
        '{6'd17, 6'd49, 6'd36, 6'd39}, '{6'd44, 6'd9,  6'd54, 6'd56},
        '{6'd39, 6'd30, 6'd34, 6'd24}, '{6'd13, 6'd50, 6'd10, 6'd17},
        '{6'd25, 6'd29, 6'd39, 6'd43}, '{6'd8,  6'd35, 6'd56, 6'd22}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, nstate;
    logic [63:0] ks [NW+1];
    logic [63:0] ts [3];
    logic [63:0] v  [NW];
    logic [6:0]  rnd, rnext;
    logic [4:0]  sidx;
    logic [3:0]  kptr, kidx;
    logic [1:0]  tptr, tnext;
    logic        accept, last, add_now;
    logic [63:0] kpar;
    logic [63:0] v0  [NW];
    logic [63:0] sk  [NW];
    logic [63:0] res [NW];
    logic [63:0] w   [UNROLL+1][NW];
    logic [63:0] mx  [UNROLL][NW];
    logic [2:0]  rd  [UNROLL];

    function automatic logic [63:0] rotl(input logic [63:0] x, input logic [5:0] n);
        rotl = (x << n) | (x >> (7'd64 - {1'b0, n}));
    endfunction

    function automatic logic [5:0] rot_amt(input logic [2:0] d, input int unsigned j);
        if (NW == 4) rot_amt = ROT4[d][j[0]];
        else         rot_amt = ROT8[d][j[1:0]];
    endfunction

    function automatic int unsigned perm(input int unsigned i);
        perm = i;
        if (NW == 4) begin
            case (i)
                1: perm = 3;
                3: perm = 1;
                default: perm = i;
            endcase
        end else begin
            case (i)
                0: perm = 2;
                1: perm = 1;
                2: perm = 4;
                3: perm = 7;
                4: perm = 6;
                5: perm = 5;
                6: perm = 0;
                default: perm = 3;
            endcase
        end
    endfunction

    assign rnext   = rnd + 7'(UNROLL);
    assign add_now = (rnext[1:0] == 2'b00);
    assign last    = (rnext == 7'(NR));
    assign tnext   = (tptr == 2'd2) ? 2'd0 : tptr + 2'd1;

    always_comb begin : fsm_next
        nstate   = state;
        accept   = 1'b0;
        outReady = 1'b0;
        case (state)
            IDLE: begin
                outReady = 1'b1;
                if (inValid) begin
                    accept = 1'b1;
                    nstate = RUN;
                end
            end
            RUN:     if (last) nstate = DONE;
            DONE:    if (inReady) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Subkey 0 is folded into the accept edge and every later subkey is added at
    // the end of the cycle that completes its 4-round group, so a cycle never
    // carries more than one subkey add and subkey 18 lands on the last RUN cycle.
    always_comb begin : accept_path
        kpar = C240;
        for (int unsigned i = 0; i < NW; i++) begin
            kpar  = kpar ^ inKey[64*i +: 64];
            v0[i] = inBlock[64*i +: 64] + inKey[64*i +: 64];
        end
        v0[NW-3] = v0[NW-3] + inTweak[63:0];
        v0[NW-2] = v0[NW-2] + inTweak[127:64];
    end

    always_comb begin : subkey
        kidx = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            sk[i] = '0;
            kidx  = kptr + 4'(i);
            if (kidx > 4'(NW)) kidx = kidx - 4'(NW + 1);
            for (int unsigned m = 0; m <= NW; m++) begin
                if (kidx == 4'(m)) sk[i] = ks[m];
            end
        end
        sk[NW-3] = sk[NW-3] + ts[tptr];
        sk[NW-2] = sk[NW-2] + ts[tnext];
        sk[NW-1] = sk[NW-1] + {59'd0, sidx};
    end

    always_comb begin : rounds
        for (int unsigned i = 0; i < NW; i++) w[0][i] = v[i];
        for (int unsigned u = 0; u < UNROLL; u++) begin
            rd[u] = rnd[2:0] + 3'(u);
            for (int unsigned j = 0; j < NW/2; j++) begin
                mx[u][2*j]   = w[u][2*j] + w[u][2*j+1];
                mx[u][2*j+1] = rotl(w[u][2*j+1], rot_amt(rd[u], j)) ^ (w[u][2*j] + w[u][2*j+1]);
            end
            for (int unsigned i = 0; i < NW; i++) w[u+1][i] = mx[u][perm(i)];
        end
        for (int unsigned i = 0; i < NW; i++) res[i] = w[UNROLL][i] + (add_now ? sk[i] : '0);
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) state <= IDLE;
        else         state <= nstate;
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            for (int unsigned m = 0; m <= NW; m++) ks[m] <= '0;
            for (int unsigned m = 0; m < 3; m++)   ts[m] <= '0;
            for (int unsigned m = 0; m < NW; m++)  v[m]  <= '0;
            rnd      <= '0;
            sidx     <= '0;
            kptr     <= '0;
            tptr     <= '0;
            outValid <= 1'b0;
            outBlock <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < NW; i++) begin
                ks[i] <= inKey[64*i +: 64];
                v[i]  <= v0[i];
            end
            ks[NW] <= kpar;
            ts[0]  <= inTweak[63:0];
            ts[1]  <= inTweak[127:64];
            ts[2]  <= inTweak[63:0] ^ inTweak[127:64];
            rnd    <= '0;
            sidx   <= 5'd1;
            kptr   <= 4'd1;
            tptr   <= 2'd1;
        end else if (state == RUN) begin
            for (int unsigned i = 0; i < NW; i++) v[i] <= res[i];
            rnd <= rnext;
            if (add_now) begin
                sidx <= sidx + 5'd1;
                kptr <= (kptr == 4'(NW)) ? '0 : kptr + 4'd1;
                tptr <= tnext;
            end
            if (last) begin
                for (int unsigned i = 0; i < NW; i++) outBlock[64*i +: 64] <= res[i];
                outValid <= 1'b1;
            end
        end else if ((state == DONE) && inReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_threefish_iter_core.sv
// Directed bench for threefish_iter_core: zero-key KATs, handshake timing,
// backpressure, reset abort and randomised vectors against a software model.
module tb_threefish_iter_core;

    localparam logic [255:0] KAT256 = {64'hD83F13E63C9F6B11, 64'h952419A1F4B16D53,
                                       64'hADF103313EAE6670, 64'h94EEEA8B1F2ADA84};
    localparam logic [63:0]  KAT512_W0 = 64'hBC2560EFC6BBA2B1;

    localparam int ROT4 [8][2] = '{'{14,16},'{52,57},'{23,40},'{5,37},
                                   '{25,33},'{46,12},'{58,22},'{32,32}};
    localparam int ROT8 [8][4] = '{'{46,36,19,37},'{33,27,14,42},'{17,49,36,39},'{44,9,54,56},
                                   '{39,30,34,24},'{13,50,10,17},'{25,29,39,43},'{8,35,56,22}};
    localparam int PI4 [4] = '{0,3,2,1};
    localparam int PI8 [8] = '{2,1,4,7,6,5,0,3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic iv_a, rdy_a, ov_a, ir_a;
    logic [255:0] key_a, blk_a, ob_a;
    logic [127:0] tw_a;
    logic iv_b, rdy_b, ov_b, ir_b;
    logic [511:0] key_b, blk_b, ob_b;
    logic [127:0] tw_b;
    logic iv_c, rdy_c, ov_c, ir_c;
    logic [511:0] key_c, blk_c, ob_c;
    logic [127:0] tw_c;

    int total = 0;
    int bad = 0;

    threefish_iter_core #(.NW(4), .UNROLL(1)) dut_a (
        .inClk(clk), .inRstN(rst_n), .inValid(iv_a), .outReady(rdy_a), .inKey(key_a),
        .inTweak(tw_a), .inBlock(blk_a), .outValid(ov_a), .inReady(ir_a), .outBlock(ob_a));
    threefish_iter_core #(.NW(8), .UNROLL(4)) dut_b (
        .inClk(clk), .inRstN(rst_n), .inValid(iv_b), .outReady(rdy_b), .inKey(key_b),
        .inTweak(tw_b), .inBlock(blk_b), .outValid(ov_b), .inReady(ir_b), .outBlock(ob_b));
    threefish_iter_core #(.NW(8), .UNROLL(2)) dut_c (
        .inClk(clk), .inRstN(rst_n), .inValid(iv_c), .outReady(rdy_c), .inKey(key_c),
        .inTweak(tw_c), .inBlock(blk_c), .outValid(ov_c), .inReady(ir_c), .outBlock(ob_c));

    function automatic logic get_rdy(input int u);
        case (u)
            0: return rdy_a;
            1: return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    function automatic logic get_ov(input int u);
        case (u)
            0: return ov_a;
            1: return ov_b;
            default: return ov_c;
        endcase
    endfunction

    function automatic logic [511:0] get_ob(input int u);
        case (u)
            0: return {256'd0, ob_a};
            1: return ob_b;
            default: return ob_c;
        endcase
    endfunction

    task automatic set_in(input int u, input logic vld, input logic [511:0] k,
                          input logic [127:0] t, input logic [511:0] p);
        case (u)
            0: begin iv_a = vld; key_a = k[255:0]; tw_a = t; blk_a = p[255:0]; end
            1: begin iv_b = vld; key_b = k; tw_b = t; blk_b = p; end
            default: begin iv_c = vld; key_c = k; tw_c = t; blk_c = p; end
        endcase
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] x;
        for (int i = 0; i < 16; i++) x[32*i +: 32] = $urandom;
        return x;
    endfunction

    function automatic logic [63:0] rl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    // Plain software Threefish, one round and one subkey at a time.
    function automatic logic [511:0] model(input int nw, input logic [511:0] k,
                                           input logic [127:0] tw, input logic [511:0] p);
        logic [63:0] ks [9];
        logic [63:0] ts [3];
        logic [63:0] v [8];
        logic [63:0] f [8];
        logic [511:0] o;
        int s, rot;
        for (int i = 0; i < 9; i++) ks[i] = '0;
        for (int i = 0; i < 8; i++) begin v[i] = '0; f[i] = '0; end
        ks[nw] = 64'h1BD11BDAA9FC1A22;
        for (int i = 0; i < nw; i++) begin
            ks[i] = k[64*i +: 64];
            ks[nw] = ks[nw] ^ ks[i];
            v[i] = p[64*i +: 64];
        end
        ts[0] = tw[63:0];
        ts[1] = tw[127:64];
        ts[2] = ts[0] ^ ts[1];
        for (int r = 0; r <= 72; r++) begin
            if (r % 4 == 0) begin
                s = r / 4;
                for (int i = 0; i < nw; i++) v[i] = v[i] + ks[(s + i) % (nw + 1)];
                v[nw-3] = v[nw-3] + ts[s % 3];
                v[nw-2] = v[nw-2] + ts[(s + 1) % 3];
                v[nw-1] = v[nw-1] + 64'(s);
            end
            if (r < 72) begin
                for (int j = 0; j < nw / 2; j++) begin
                    rot = (nw == 8) ? ROT8[r % 8][j] : ROT4[r % 8][j];
                    v[2*j] = v[2*j] + v[2*j+1];
                    v[2*j+1] = rl(v[2*j+1], rot) ^ v[2*j];
                end
                for (int i = 0; i < nw; i++) f[i] = v[(nw == 8) ? PI8[i] : PI4[i]];
                for (int i = 0; i < nw; i++) v[i] = f[i];
            end
        end
        o = '0;
        for (int i = 0; i < nw; i++) o[64*i +: 64] = v[i];
        return o;
    endfunction

    // Accept one request, then wait for outValid; lat counts edges after the accept edge.
    task automatic run_block(input int u, input logic [511:0] k, input logic [127:0] t,
                             input logic [511:0] p, input bit scr,
                             output logic [511:0] c, output int lat, output bit ok);
        int n;
        logic [511:0] r;
        n = 0;
        @(negedge clk);
        while (!get_rdy(u) && n < 200) begin @(negedge clk); n++; end
        set_in(u, 1'b1, k, t, p);
        @(negedge clk);
        r = rnd512();
        if (scr) set_in(u, 1'b0, r, r[511:384], ~r);
        else     set_in(u, 1'b0, k, t, p);
        lat = 0;
        while (!get_ov(u) && lat < 200) begin
            @(negedge clk);
            lat++;
            if (scr) begin r = rnd512(); set_in(u, 1'b0, ~r, r[255:128], r); end
        end
        ok = get_ov(u);
        c = get_ob(u);
    endtask

    task automatic test_reset();
        logic [511:0] r;
        rst_n = 1'b0;
        ir_a = 1'b1; ir_b = 1'b1; ir_c = 1'b1;
        for (int u = 0; u < 3; u++) begin r = rnd512(); set_in(u, 1'b1, r, r[127:0], ~r); end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            total++;
            if (get_ov(u) !== 1'b0) begin bad++; $display("FAIL reset_outvalid dut%0d got=%b exp=0", u, get_ov(u)); end
            total++;
            if (get_ob(u) !== '0) begin bad++; $display("FAIL reset_outblock dut%0d got=%h exp=0", u, get_ob(u)); end
        end
        for (int u = 0; u < 3; u++) set_in(u, 1'b0, '0, '0, '0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            total++;
            if (get_rdy(u) !== 1'b1) begin bad++; $display("FAIL reset_ready dut%0d got=%b exp=1", u, get_rdy(u)); end
        end
    endtask

    task automatic test_kat256();
        logic [511:0] c;
        int lat;
        bit ok;
        run_block(0, '0, '0, '0, 1'b0, c, lat, ok);
        total++;
        if (!ok || c[255:0] !== KAT256) begin bad++; $display("FAIL kat256 got=%h exp=%h", c[255:0], KAT256); end
        total++;
        if (lat !== 72) begin bad++; $display("FAIL kat256_latency got=%0d exp=72", lat); end
    endtask

    task automatic test_kat512();
        logic [511:0] c, want;
        int lat;
        bit ok;
        want = model(8, '0, '0, '0);
        run_block(1, '0, '0, '0, 1'b0, c, lat, ok);
        total++;
        if (!ok || c[63:0] !== KAT512_W0) begin bad++; $display("FAIL kat512_word0 got=%h exp=%h", c[63:0], KAT512_W0); end
        total++;
        if (c !== want) begin bad++; $display("FAIL kat512_block got=%h exp=%h", c, want); end
        total++;
        if (lat !== 18) begin bad++; $display("FAIL kat512_latency got=%0d exp=18", lat); end
    endtask

    task automatic test_back_to_back();
        int highs, first, second, n;
        highs = 0; first = -1; second = -1;
        ir_b = 1'b1;
        @(negedge clk);
        set_in(1, 1'b1, '0, '0, '0);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ov_b === 1'b1) begin
                highs++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
                total++;
                if (ob_b[63:0] !== KAT512_W0) begin bad++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, ob_b[63:0], KAT512_W0); end
            end
        end
        set_in(1, 1'b0, '0, '0, '0);
        total++;
        if (highs !== 3) begin bad++; $display("FAIL b2b_valid_cycles got=%0d exp=3", highs); end
        total++;
        if (first !== 18) begin bad++; $display("FAIL b2b_first got=%0d exp=18", first); end
        total++;
        if (second - first !== 20) begin bad++; $display("FAIL b2b_spacing got=%0d exp=20", second - first); end
        n = 0;
        while (rdy_b !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        total++;
        if (rdy_b !== 1'b1) begin bad++; $display("FAIL b2b_drain got=%b exp=1", rdy_b); end
    endtask

    task automatic test_backpressure();
        logic [511:0] k, p, tr, c, want, got_ob;
        int lat;
        bit ok, stable;
        logic got_ov, got_rdy;
        k = rnd512(); p = rnd512(); tr = rnd512();
        want = model(8, k, tr[127:0], p);
        ir_b = 1'b0;
        run_block(1, k, tr[127:0], p, 1'b0, c, lat, ok);
        total++;
        if (!ok || c !== want) begin bad++; $display("FAIL bp_result got=%h exp=%h", c, want); end
        set_in(1, 1'b1, ~k, ~tr[127:0], ~p);
        stable = 1'b1; got_ov = 1'b1; got_rdy = 1'b0; got_ob = want;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (stable && (ov_b !== 1'b1 || rdy_b !== 1'b0 || ob_b !== want)) begin
                stable = 1'b0; got_ov = ov_b; got_rdy = rdy_b; got_ob = ob_b;
            end
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_hold got ov=%b rdy=%b ob=%h exp ov=1 rdy=0 ob=%h", got_ov, got_rdy, got_ob, want);
        end
        ir_b = 1'b1;
        set_in(1, 1'b0, '0, '0, '0);
        @(negedge clk);
        total++;
        if (rdy_b !== 1'b1 || ov_b !== 1'b0) begin bad++; $display("FAIL bp_release got rdy=%b ov=%b exp rdy=1 ov=0", rdy_b, ov_b); end
        total++;
        if (ob_b !== want) begin bad++; $display("FAIL bp_keep_block got=%h exp=%h", ob_b, want); end
        @(negedge clk);
        total++;
        if (rdy_b !== 1'b1) begin bad++; $display("FAIL bp_no_accept got=%b exp=1", rdy_b); end
    endtask

    task automatic test_abort();
        logic [511:0] r, c;
        int lat, n;
        bit ok;
        r = rnd512();
        n = 0;
        @(negedge clk);
        while (rdy_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        set_in(0, 1'b1, r, r[127:0], ~r);
        @(negedge clk);
        set_in(0, 1'b0, '0, '0, '0);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (ov_a !== 1'b0 || ob_a !== '0) begin bad++; $display("FAIL abort_clear got ov=%b ob=%h exp ov=0 ob=0", ov_a, ob_a); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (rdy_a !== 1'b1) begin bad++; $display("FAIL abort_idle got=%b exp=1", rdy_a); end
        run_block(0, '0, '0, '0, 1'b0, c, lat, ok);
        total++;
        if (!ok || c[255:0] !== KAT256) begin bad++; $display("FAIL abort_fresh got=%h exp=%h", c[255:0], KAT256); end
        total++;
        if (lat !== 72) begin bad++; $display("FAIL abort_latency got=%0d exp=72", lat); end
    endtask

    task automatic test_random();
        logic [511:0] k, p, tr, c, want;
        int lat;
        bit ok;
        ir_c = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            k = rnd512(); p = rnd512(); tr = rnd512();
            want = model(8, k, tr[127:0], p);
            run_block(2, k, tr[127:0], p, 1'b1, c, lat, ok);
            total++;
            if (!ok || c !== want) begin bad++; $display("FAIL random n=%0d got=%h exp=%h", n, c, want); end
            total++;
            if (lat !== 36) begin bad++; $display("FAIL random_latency n=%0d got=%0d exp=36", n, lat); end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_kat256();
        test_kat512();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/threefish_iter_core.md
# threefish_iter_core

Iterative, parametrised Threefish encryption engine for block widths of 256 or 512 bits. It computes all 72 rounds plus the 19-subkey schedule on-chip, processing UNROLL rounds per clock. It replaces the single-round combinational datapath as the encryption unit behind the Skein/Threefish top level. A valid/ready handshake on both sides lets it sit between the input buffer and the output collector.

## Interface
- NW, default 8: number of 64-bit words per block; legal values 4 (Threefish-256) or 8 (Threefish-512).
- UNROLL, default 1: rounds computed per cycle; legal values 1, 2 or 4.
- inClk  input  1  sole clock; all state changes on its rising edge.
- inRstN  input  1  asynchronous, active-low reset.
- inValid  input  1  request present on inKey/inTweak/inBlock.
- outReady  output  1  engine can accept a request.
- inKey  input  64*NW  cipher key; word i is in bits [64i+63:64i].
- inTweak  input  128  tweak; t0 is in bits [63:0] and t1 is in bits [127:64].
- inBlock  input  64*NW  plaintext, with the same word packing as inKey.
- outValid  output  1  outBlock holds a finished ciphertext.
- inReady  input  1  downstream accepts outBlock.
- outBlock  output  64*NW  ciphertext, with the same word packing.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE and clears every register.
  - Reset values: outValid=0, outBlock=0, round counter=0, subkey index=0.
  - outReady=1 exactly when the state is IDLE.
- IDLE: on inValid&&outReady, register the key words k0..k(NW-1) and the tweak words t0 and t1.
  - Register kNW = 0x1BD11BDAA9FC1A22 ^ k0 ^ … ^ k(NW-1).
  - Register t2 = t0 ^ t1.
  - Register the block, then go to RUN with round r=0 and subkey s=0.
- Subkey s, for word i:
  - Base value is k[(s+i) mod (NW+1)].
  - Add t[s mod 3] to word NW-3.
  - Add t[(s+1) mod 3] to word NW-2.
  - Add s to word NW-1.
  - s fits in 5 bits and is zero-extended to 64 bits.
- RUN cycle: apply UNROLL consecutive rounds r..r+UNROLL-1. For each round:
  - When r mod 4 == 0, add subkey s=r/4 word-wise first.
  - Then do the MIX step on word pairs (2j, 2j+1): y0=x0+x1, y1=rotl(x1,R[r mod 8][j])^y0.
  - Then apply the word permutation π.
  - R and π are the Skein 1.3 constants for the selected NW.
- All additions are mod 2^64; carries are discarded.
- After the last RUN cycle (r+UNROLL == 72), add subkey 18 and register the result into outBlock. Set outValid=1 and go to DONE.
- DONE: hold outBlock and outValid stable until inReady=1.
  - On the outValid&&inReady edge: outValid→0, state→IDLE. outBlock keeps its last value.
- inValid is ignored outside IDLE. Inputs are sampled only on the accept edge, so later changes to inKey/inTweak/inBlock have no effect.
- Key schedule words are held in registers and indexed modulo NW+1 with a counter. No per-round key memory is used.
- Illegal NW or UNROLL values must stop elaboration through a generate-time error.

## Timing
- Accept at edge T. RUN lasts 72/UNROLL cycles (72, 36 or 18). outValid rises at edge T+72/UNROLL.
- Throughput is one block per 72/UNROLL+2 cycles when inReady is held at 1:
  - 1 cycle in IDLE.
  - 72/UNROLL cycles in RUN.
  - 1 cycle in DONE.
- With inReady=1 already high, DONE lasts exactly one cycle.
- inRstN low mid-RUN or in DONE aborts the block immediately and asynchronously. Required state after that:
  - outValid=0 with no partial result exposed.
  - The state is IDLE one cycle after release.
- The critical path is UNROLL rounds plus up to UNROLL/4 subkey adds, with a maximum of one add per cycle for UNROLL≤4.

## Test plan
- Reset: hold inRstN=0 with inValid=1 → outValid=0, outBlock=0, no accept. After release, outReady=1.
- NW=4, UNROLL=1, key=tweak=plaintext=0 → outBlock equals the Skein 1.3 Threefish-256 zero KAT.
  - Ciphertext bytes: 84DA2A1F8BEAEE94 7066AE3E3103F1AD 536DB1F4A1192495 116B9F3CE6133FD8 (little-endian words).
  - outValid rises exactly 72 cycles after accept.
- NW=8, UNROLL=4, all-zero inputs → outBlock equals the Threefish-512 zero KAT (first word bytes B1A2BBC6EF6025BC). outValid rises after 18 cycles.
- NW=8, UNROLL=2, random key/tweak/block sets (≥1000) → outBlock matches the C reference model.
  - Inputs are toggled randomly after accept and must not change the result.
- Backpressure: hold inReady=0 for 50 cycles in DONE → outBlock/outValid stable, outReady=0, and a second inValid is not accepted. Raising inReady gives outReady=1 on the next cycle.
- Pulse inRstN low at RUN cycle 30, then send a fresh request → correct ciphertext for the fresh request, with no trace of the aborted block.
